// File: rtl/traffic_signal_monitor.sv
// Watches the lamp drives of a traffic signal controller, tracks the phase sequence
// and dwell time, and raises sticky errors for illegal codes, order, short or long phases.
module traffic_signal_monitor #(
  parameter int CNT_W     = 8,
  parameter int MIN_PHASE = 1,
  parameter int MAX_PHASE = 200
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             clear_err,
  output logic [1:0]       phase,
  output logic             in_fault,
  output logic [CNT_W-1:0] dwell,
  output logic             phase_done,
  output logic [CNT_W-1:0] last_dwell,
  output logic [15:0]      cycle_cnt,
  output logic             seq_err,
  output logic             lamp_err,
  output logic             short_err,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RED,
    S_YELLOW,
    S_GREEN,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_SAT = '1;
  localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_DW    = CNT_W'(MIN_PHASE);
  localparam logic [CNT_W-1:0] MAX_DW    = CNT_W'(MAX_PHASE);

  state_t state, state_n;

  logic [2:0]       code;
  logic             one_hot;
  logic             all_zero;
  state_t           lamp_state;
  state_t           next_legal;

  logic [1:0]       phase_n;
  logic             in_fault_n;
  logic [CNT_W-1:0] dwell_n;
  logic             phase_done_n;
  logic [CNT_W-1:0] last_dwell_n;
  logic [15:0]      cycle_cnt_n;
  logic             set_seq, set_lamp, set_short, set_timeout;

  assign code     = {red, yellow, green};
  assign all_zero = (code == 3'b000);
  assign one_hot  = (code == 3'b100) || (code == 3'b010) || (code == 3'b001);

  always_comb begin
    lamp_state = S_IDLE;
    case (code)
      3'b100:  lamp_state = S_RED;
      3'b010:  lamp_state = S_YELLOW;
      3'b001:  lamp_state = S_GREEN;
      default: lamp_state = S_IDLE;
    endcase
  end

  always_comb begin
    next_legal = S_IDLE;
    case (state)
      S_RED:    next_legal = S_YELLOW;
      S_YELLOW: next_legal = S_GREEN;
      S_GREEN:  next_legal = S_RED;
      default:  next_legal = S_IDLE;
    endcase
  end

  // Next-state and next-output decode; every registered output is computed here
  always_comb begin
    state_n      = state;
    dwell_n      = dwell;
    last_dwell_n = last_dwell;
    phase_done_n = 1'b0;
    cycle_cnt_n  = cycle_cnt;
    set_seq      = 1'b0;
    set_lamp     = 1'b0;
    set_short    = 1'b0;
    set_timeout  = 1'b0;

    case (state)
      S_IDLE: begin
        if (!all_zero) begin
          if (!one_hot) begin
            state_n  = S_FAULT;
            set_lamp = 1'b1;
          end else if (lamp_state == S_RED) begin
            state_n = S_RED;
            dwell_n = DWELL_ONE;
          end else begin
            state_n = S_FAULT;
            set_seq = 1'b1;
          end
        end
      end

      S_FAULT: begin
        if (lamp_state == S_RED) begin
          state_n = S_RED;
          dwell_n = DWELL_ONE;
        end
      end

      default: begin
        if (!one_hot) begin
          state_n  = S_FAULT;
          dwell_n  = '0;
          set_lamp = 1'b1;
        end else if (lamp_state == state) begin
          // Timeout fires on the sample that would push dwell beyond the limit
          if (dwell == MAX_DW) set_timeout = 1'b1;
          if (dwell != DWELL_SAT) dwell_n = dwell + DWELL_ONE;
        end else if (lamp_state == next_legal) begin
          if (dwell < MIN_DW) set_short = 1'b1;
          state_n      = next_legal;
          last_dwell_n = dwell;
          dwell_n      = DWELL_ONE;
          phase_done_n = 1'b1;
          if (state == S_GREEN) cycle_cnt_n = cycle_cnt + 16'd1;
        end else begin
          state_n = S_FAULT;
          dwell_n = '0;
          set_seq = 1'b1;
        end
      end
    endcase

    case (state_n)
      S_RED:    phase_n = 2'd1;
      S_YELLOW: phase_n = 2'd2;
      S_GREEN:  phase_n = 2'd3;
      default:  phase_n = 2'd0;
    endcase
    in_fault_n = (state_n == S_FAULT);
  end

  // Error flags: a set condition on the same edge overrides clear_err
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      phase       <= 2'd0;
      in_fault    <= 1'b0;
      dwell       <= '0;
      last_dwell  <= '0;
      phase_done  <= 1'b0;
      cycle_cnt   <= 16'd0;
      seq_err     <= 1'b0;
      lamp_err    <= 1'b0;
      short_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      in_fault    <= in_fault_n;
      dwell       <= dwell_n;
      last_dwell  <= last_dwell_n;
      phase_done  <= phase_done_n;
      cycle_cnt   <= cycle_cnt_n;
      seq_err     <= (seq_err     & ~clear_err) | set_seq;
      lamp_err    <= (lamp_err    & ~clear_err) | set_lamp;
      short_err   <= (short_err   & ~clear_err) | set_short;
      timeout_err <= (timeout_err & ~clear_err) | set_timeout;
    end
  end

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Bench for traffic_signal_monitor: fixed vector tables, hand sequences for the
// multi-cycle corners, and randomized traffic checked against a phase-level model.
module tb_traffic_signal_monitor;

  localparam int MAXP = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic red = 1'b0, yellow = 1'b0, green = 1'b0, clear_err = 1'b0;

  logic [1:0]  phase_a, phase_b;
  logic        in_fault_a, in_fault_b, phase_done_a, phase_done_b;
  logic [7:0]  dwell_a, dwell_b, last_dwell_a, last_dwell_b;
  logic [15:0] cycle_cnt_a, cycle_cnt_b;
  logic        seq_a, lamp_a, short_a, to_a, seq_b, lamp_b, short_b, to_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  traffic_signal_monitor #(.CNT_W(8), .MIN_PHASE(1), .MAX_PHASE(MAXP)) dut_a (
    .clk(clk), .reset_n(reset_n), .red(red), .yellow(yellow), .green(green),
    .clear_err(clear_err), .phase(phase_a), .in_fault(in_fault_a), .dwell(dwell_a),
    .phase_done(phase_done_a), .last_dwell(last_dwell_a), .cycle_cnt(cycle_cnt_a),
    .seq_err(seq_a), .lamp_err(lamp_a), .short_err(short_a), .timeout_err(to_a)
  );

  traffic_signal_monitor #(.CNT_W(8), .MIN_PHASE(2), .MAX_PHASE(MAXP)) dut_b (
    .clk(clk), .reset_n(reset_n), .red(red), .yellow(yellow), .green(green),
    .clear_err(clear_err), .phase(phase_b), .in_fault(in_fault_b), .dwell(dwell_b),
    .phase_done(phase_done_b), .last_dwell(last_dwell_b), .cycle_cnt(cycle_cnt_b),
    .seq_err(seq_b), .lamp_err(lamp_b), .short_err(short_b), .timeout_err(to_b)
  );

  typedef struct packed {
    logic [1:0]  phase;
    logic        in_fault;
    logic [7:0]  dwell;
    logic [7:0]  last_dwell;
    logic        phase_done;
    logic [15:0] cycle_cnt;
    logic        seq_err;
    logic        lamp_err;
    logic        short_err;
    logic        timeout_err;
  } obs_t;

  // Phase-level model: ph is 1..3 for a lamp phase, 0 otherwise; flt marks FAULT
  typedef struct {
    int ph;
    bit flt;
    int dw;
    int last;
    bit done;
    int cyc;
    bit se, le, sh, to;
    int min_p;
  } model_t;

  typedef struct {
    bit   r, y, g, clr;
    obs_t exp;
  } vec_t;

  model_t m_a, m_b;

  function automatic obs_t mk(int ph, bit flt, int dw, int last, bit done, int cyc,
                              bit se, bit le, bit sh, bit to);
    obs_t o;
    o.phase = 2'(ph); o.in_fault = flt; o.dwell = 8'(dw); o.last_dwell = 8'(last);
    o.phase_done = done; o.cycle_cnt = 16'(cyc);
    o.seq_err = se; o.lamp_err = le; o.short_err = sh; o.timeout_err = to;
    return o;
  endfunction

  function automatic model_t model_reset(int min_p);
    model_t m;
    m.ph = 0; m.flt = 0; m.dw = 0; m.last = 0; m.done = 0; m.cyc = 0;
    m.se = 0; m.le = 0; m.sh = 0; m.to = 0; m.min_p = min_p;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, bit r, bit y, bit g, bit clr);
    int hot = int'(r) + int'(y) + int'(g);
    int lamp = r ? 1 : (y ? 2 : (g ? 3 : 0));
    bit s_se = 0, s_le = 0, s_sh = 0, s_to = 0;
    m.done = 0;
    if (m.flt) begin
      if (hot == 1 && lamp == 1) begin m.flt = 0; m.ph = 1; m.dw = 1; end
    end else if (m.ph == 0) begin
      if (hot > 1) begin m.flt = 1; s_le = 1; end
      else if (hot == 1) begin
        if (lamp == 1) begin m.ph = 1; m.dw = 1; end
        else begin m.flt = 1; s_se = 1; end
      end
    end else if (hot != 1) begin
      m.flt = 1; m.ph = 0; m.dw = 0; s_le = 1;
    end else if (lamp == m.ph) begin
      if (m.dw == MAXP) s_to = 1;
      if (m.dw < 255) m.dw = m.dw + 1;
    end else if (lamp == m.ph % 3 + 1) begin
      if (m.dw < m.min_p) s_sh = 1;
      m.last = m.dw; m.dw = 1; m.done = 1;
      if (m.ph == 3) m.cyc = (m.cyc + 1) % 65536;
      m.ph = lamp;
    end else begin
      m.flt = 1; m.ph = 0; m.dw = 0; s_se = 1;
    end
    m.se = (m.se && !clr) || s_se;
    m.le = (m.le && !clr) || s_le;
    m.sh = (m.sh && !clr) || s_sh;
    m.to = (m.to && !clr) || s_to;
    return m;
  endfunction

  function automatic obs_t to_obs(model_t m);
    return mk(m.flt ? 0 : m.ph, m.flt, m.dw, m.last, m.done, m.cyc, m.se, m.le, m.sh, m.to);
  endfunction

  function automatic obs_t get_a();
    return mk(int'(phase_a), in_fault_a, int'(dwell_a), int'(last_dwell_a), phase_done_a,
              int'(cycle_cnt_a), seq_a, lamp_a, short_a, to_a);
  endfunction

  function automatic obs_t get_b();
    return mk(int'(phase_b), in_fault_b, int'(dwell_b), int'(last_dwell_b), phase_done_b,
              int'(cycle_cnt_b), seq_b, lamp_b, short_b, to_b);
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("ph=%0d flt=%0d dw=%0d last=%0d done=%0d cyc=%0d err(seq,lamp,short,to)=%b%b%b%b",
                     o.phase, o.in_fault, o.dwell, o.last_dwell, o.phase_done, o.cycle_cnt,
                     o.seq_err, o.lamp_err, o.short_err, o.timeout_err);
  endfunction

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
    end
  endtask

  // One sample: drive on the falling edge, check both DUTs just after the rising edge
  task automatic applyStimulus(input bit r, input bit y, input bit g, input bit clr,
                               input string name);
    @(negedge clk);
    red = r; yellow = y; green = g; clear_err = clr;
    @(posedge clk);
    #1;
    m_a = model_step(m_a, r, y, g, clr);
    m_b = model_step(m_b, r, y, g, clr);
    checkOutput({name, "/model_a"}, get_a(), to_obs(m_a));
    checkOutput({name, "/model_b"}, get_b(), to_obs(m_b));
  endtask

  task automatic doReset(input string name);
    @(negedge clk);
    reset_n = 1'b0; red = 0; yellow = 0; green = 0; clear_err = 0;
    m_a = model_reset(1);
    m_b = model_reset(2);
    @(posedge clk);
    #1;
    checkOutput({name, "/reset_a"}, get_a(), '0);
    checkOutput({name, "/reset_b"}, get_b(), '0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = '{1, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1] = '{0, 1, 0, 0, mk(2, 0, 1, 1, 1, 0, 0, 0, 0, 0)};
    tbl[2] = '{0, 0, 1, 0, mk(3, 0, 1, 1, 1, 0, 0, 0, 0, 0)};
    tbl[3] = '{1, 0, 0, 0, mk(1, 0, 1, 1, 1, 1, 0, 0, 0, 0)};
    tbl[4] = '{0, 1, 0, 0, mk(2, 0, 1, 1, 1, 1, 0, 0, 0, 0)};
    tbl[5] = '{0, 0, 1, 0, mk(3, 0, 1, 1, 1, 1, 0, 0, 0, 0)};

    m_a = model_reset(1);
    m_b = model_reset(2);

    // Clean two full cycles, one sample per phase
    doReset("seq");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(tbl[k].r, tbl[k].y, tbl[k].g, tbl[k].clr, $sformatf("seq%0d", k));
      checkOutput($sformatf("seq%0d", k), get_a(), tbl[k].exp);
    end

    // Illegal order RED->GREEN, recovery through RED, then clear
    doReset("order");
    applyStimulus(1, 0, 0, 0, "order_r1");
    applyStimulus(1, 0, 0, 0, "order_r2");
    checkOutput("order_r2", get_a(), mk(1, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, 1, 0, "order_g");
    checkOutput("order_g", get_a(), mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    applyStimulus(1, 0, 0, 0, "order_recover");
    checkOutput("order_recover", get_a(), mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    applyStimulus(1, 0, 0, 1, "order_clear");
    checkOutput("order_clear", get_a(), mk(1, 0, 2, 0, 0, 0, 0, 0, 0, 0));

    // Dwell limit: timeout on the sample after dwell reaches the maximum
    doReset("timeout");
    for (int k = 1; k <= 4; k++) applyStimulus(1, 0, 0, 0, $sformatf("timeout_r%0d", k));
    checkOutput("timeout_at_max", get_a(), mk(1, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(1, 0, 0, 0, "timeout_r5");
    checkOutput("timeout_over", get_a(), mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 1));

    // Multi-hot in YELLOW with a simultaneous clear: set wins
    doReset("multihot");
    applyStimulus(1, 0, 0, 0, "multihot_r");
    applyStimulus(0, 1, 0, 0, "multihot_y");
    applyStimulus(1, 1, 0, 1, "multihot_ry");
    checkOutput("multihot_ry", get_a(), mk(0, 1, 0, 1, 0, 0, 0, 1, 0, 0));

    // Short phase on the MIN_PHASE=2 instance
    doReset("short");
    applyStimulus(1, 0, 0, 0, "short_r");
    applyStimulus(0, 1, 0, 0, "short_y");
    checkOutput("short_y", get_b(), mk(2, 0, 1, 1, 1, 0, 0, 0, 1, 0));
    checkOutput("short_y_min1", get_a(), mk(2, 0, 1, 1, 1, 0, 0, 0, 0, 0));

    // Dwell counter saturation at 255
    doReset("sat");
    for (int k = 1; k <= 256; k++) applyStimulus(1, 0, 0, 0, $sformatf("sat%0d", k));
    checkOutput("sat_hold", get_a(), mk(1, 0, 255, 0, 0, 0, 0, 0, 0, 1));

    // Asynchronous reset mid-GREEN with cycle_cnt=3
    doReset("async");
    for (int k = 0; k < 12; k++)
      applyStimulus(k % 3 == 0, k % 3 == 1, k % 3 == 2, 0, $sformatf("async%0d", k));
    checkOutput("async_green", get_a(), mk(3, 0, 1, 1, 1, 3, 0, 0, 0, 0));
    #2;
    reset_n = 1'b0;
    m_a = model_reset(1);
    m_b = model_reset(2);
    #1;
    checkOutput("async_low_a", get_a(), '0);
    checkOutput("async_low_b", get_b(), '0);
    @(negedge clk);
    red = 0; yellow = 0; green = 0; clear_err = 0;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, $sformatf("idle%0d", k));
      checkOutput($sformatf("idle%0d", k), get_a(), '0);
    end

    // Randomized traffic, alternating between change-heavy and hold-heavy stretches
    doReset("rand");
    for (int i = 0; i < 1200; i++) begin
      int sel, cur, lamp, hold_w, next_w;
      bit r, y, g, clr;
      bit [2:0] code;
      cur    = m_a.flt ? 0 : m_a.ph;
      next_w = ((i / 100) % 2 == 0) ? 45 : 15;
      hold_w = 85;
      sel    = $urandom_range(0, 99);
      if (sel < next_w)      lamp = (cur == 0) ? 1 : cur % 3 + 1;
      else if (sel < hold_w) lamp = (cur == 0) ? 1 : cur;
      else if (sel < 92)     lamp = $urandom_range(1, 3);
      else                   lamp = 0;
      if (lamp == 0) code = 3'($urandom_range(0, 7));
      else           code = 3'b100 >> (lamp - 1);
      r = code[2]; y = code[1]; g = code[0];
      clr = ($urandom_range(0, 19) == 0);
      applyStimulus(r, y, g, clr, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
